// File: rtl/acc_sum_sampler.sv
// Window sampler for the accumulator's running sum: every WINDOW cycles the
// sum delta is pushed into a show-ahead FIFO. Define ACC_AVG_EN to push delta/WINDOW instead.
module acc_sum_sampler #(
    parameter int WINDOW = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              sum,
    output logic [15:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic [7:0]               drop_cnt
);
    localparam int WW = $clog2(WINDOW);
    localparam int PW = $clog2(DEPTH);
    localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);
    localparam logic [PW:0]   LFULL = (PW + 1)'(DEPTH);

    logic [WW-1:0]             wcnt;
    logic [15:0]               prev;
    logic [DEPTH-1:0][15:0]    mem;
    logic [PW-1:0]             wr_ptr, rd_ptr;
    logic                      cap, full, pop, push, drop;
    logic [15:0]               delta, push_val;

    always_comb begin
        cap   = (wcnt == WLAST);
        delta = sum - prev;
`ifdef ACC_AVG_EN
        push_val = delta >> WW;
`else
        push_val = delta;
`endif
        full = (level == LFULL);
        pop  = out_valid && out_ready;
        // A pop on the same edge frees the slot a full FIFO needs.
        push = cap && (!full || pop);
        drop = cap && full && !pop;
    end

    assign out_valid = (level != '0);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt     <= '0;
            prev     <= '0;
            mem      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            wcnt <= wcnt + 1'b1;
            // prev follows every capture, dropped or not, so deltas never span windows.
            if (cap)
                prev <= sum;
            if (push) begin
                mem[wr_ptr] <= push_val;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_acc_sum_sampler.sv
// Bench for acc_sum_sampler: directed scenarios plus random traffic, checked
// against a queue-based window model.
module tb_acc_sum_sampler;
    localparam int WINDOW = 4;
    localparam int DEPTH  = 4;
`ifdef ACC_AVG_EN
    localparam int SH = 2;
`else
    localparam int SH = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sum = '0;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic [2:0]  level;
    logic        ovf;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    // window model
    logic [15:0] q[$];
    logic [15:0] mprev;
    int          nedge;
    logic        movf;
    int          mdrop;

    always #5 clk = ~clk;

    acc_sum_sampler #(.WINDOW(WINDOW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .sum(sum), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .level(level), .ovf(ovf), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid", {15'd0, out_valid}, {15'd0, q.size() != 0});
        chk("level", {13'd0, level}, 16'(q.size()));
        if (q.size() != 0)
            chk("data", out_data, q[0]);
        chk("ovf", {15'd0, ovf}, {15'd0, movf});
        chk("drop_cnt", {8'd0, drop_cnt}, 16'(mdrop));
    endtask

    task automatic model_edge(input logic [15:0] s, input logic r);
        logic [15:0] d;
        nedge++;
        if (r && q.size() != 0)
            void'(q.pop_front());
        if (nedge % WINDOW == 0) begin
            d = (s - mprev) >> SH;
            mprev = s;
            if (q.size() < DEPTH)
                q.push_back(d);
            else begin
                movf = 1'b1;
                if (mdrop < 255) mdrop++;
            end
        end
    endtask

    task automatic step(input logic [15:0] s, input logic r);
        sum = s;
        out_ready = r;
        @(posedge clk);
        model_edge(s, r);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sum = 16'($urandom);
        out_ready = 1'($urandom);
        @(posedge clk);
        q.delete();
        mprev = '0;
        nedge = 0;
        movf = 1'b0;
        mdrop = 0;
        #1;
        rst = 1'b0;
        chk("rst_data", out_data, 16'd0);
        check_all();
    endtask

    initial begin
        logic [15:0] held;
        logic [15:0] s;

        // reset state
        do_reset();

        // basic window
        for (int i = 1; i <= 8; i++) begin
            step(16'(10 * i), 1'b1);
            if (i == 4) chk("basic_first", out_data, 16'(40 >> SH));
            if (i == 8) chk("basic_second", out_data, 16'(40 >> SH));
        end

        // wrap
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            s = 16'($urandom);
            if (i == 4) s = 16'hFFF0;
            if (i == 8) s = 16'h0010;
            step(s, 1'b1);
        end
        chk("wrap", out_data, 16'(16'h0020 >> SH));

        // back-pressure and overflow
        do_reset();
        s = '0;
        for (int i = 1; i <= 24; i++) begin
            s = s + 16'd4;
            step(s, 1'b0);
            if (i == 16) chk("bp_level4", {13'd0, level}, 16'd4);
        end
        chk("bp_ovf", {15'd0, ovf}, 16'd1);
        chk("bp_drops", {8'd0, drop_cnt}, 16'd2);
        for (int i = 0; i < 4; i++) begin
            chk("bp_drain", out_data, 16'(16 >> SH));
            s = s + 16'd4;
            step(s, 1'b1);
        end

        // full with simultaneous pop
        do_reset();
        s = '0;
        for (int i = 1; i <= 19; i++) begin
            s = s + 16'd3;
            step(s, 1'b0);
        end
        s = s + 16'd3;
        step(s, 1'b1);
        chk("fullpop_level", {13'd0, level}, 16'd4);
        chk("fullpop_ovf", {15'd0, ovf}, 16'd0);

        // stall stability
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            step(16'($urandom), 1'b0);
            chk("stall_hold", out_data, held);
        end

        // reset mid-operation with level=3, ovf=1
        step(16'($urandom), 1'b1);
        chk("pre_rst_level", {13'd0, level}, 16'd3);
        chk("pre_rst_ovf", {15'd0, ovf}, 16'd1);
        do_reset();
        chk("post_rst_level", {13'd0, level}, 16'd0);
        for (int i = 1; i <= 4; i++) step(16'h1234 + 16'(i), 1'b0);
        chk("post_rst_cap", out_data, 16'(16'h1238 >> SH));

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0)
                do_reset();
            else
                step(16'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
